// File: rtl/day9_sequencer.sv
// day9_sequencer: job sequencer for the rectangle-area datapath.
// Accepts coordinate beats, clears the datapath at the start of each job,
// feeds one point per accepted beat, waits out the datapath pipeline after
// the last point, then captures the largest area on a valid/ready result port.
//
// state | meaning
// ------+-----------------------------------------------------------------
// ARM   | idle between jobs; datapath held cleared; first point accepted here
// FEED  | job in progress; points streamed to the datapath
// DRAIN | last point sent; counting down the datapath latency
// DONE  | result captured and presented until out_ready
module day9_sequencer #(
    parameter int W          = 17,
    parameter int DP_LATENCY = 6,
    parameter int CNT_W      = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_x,
    input  logic [W-1:0]     in_y,
    input  logic             in_last,
    output logic             dp_reset,
    output logic [W-1:0]     dp_x,
    output logic [W-1:0]     dp_y,
    input  logic [2*W-1:0]   dp_area,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   out_area,
    output logic [CNT_W-1:0] out_count,
    output logic             busy
);

    localparam int DW = $clog2(DP_LATENCY + 1);

    typedef enum logic [1:0] {
        S_ARM   = 2'd0,
        S_FEED  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             w_accept;
    logic             w_drain_done;
    logic [W-1:0]     r_dp_x;
    logic [W-1:0]     r_dp_y;
    logic [2*W-1:0]   r_out_area;
    logic [CNT_W-1:0] r_out_count;
    logic [DW-1:0]    r_drain_cnt;

    assign w_accept     = in_valid && in_ready;
    assign w_drain_done = (r_state == S_DRAIN) && (r_drain_cnt == '0);

    // The datapath is held cleared while arming so a stale point from the
    // previous job never contributes to the next one.
    assign dp_reset  = reset | (r_state == S_ARM);
    assign dp_x      = r_dp_x;
    assign dp_y      = r_dp_y;
    assign out_area  = r_out_area;
    assign out_count = r_out_count;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_ARM;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and state-decoded outputs; outputs depend on state only,
    // so there is no combinational path from in_valid or out_ready.
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b0;
        case (r_state)
            S_ARM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = in_last ? S_DRAIN : S_FEED;
                end
            end
            S_FEED: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid && in_last) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (r_drain_cnt == '0) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = S_ARM;
                end
            end
            default: begin
                w_state_next = S_ARM;
            end
        endcase
    end

    // Point register: updates only on accepted beats, holds across gaps.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_dp_x <= '0;
            r_dp_y <= '0;
        end else if (w_accept) begin
            r_dp_x <= in_x;
            r_dp_y <= in_y;
        end
    end

    // Saturating point counter; restarts at 1 on the first accept of a job.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_out_count <= '0;
        end else if (w_accept) begin
            if (r_state == S_ARM) begin
                r_out_count <= CNT_W'(1);
            end else if (r_out_count != '1) begin
                r_out_count <= r_out_count + CNT_W'(1);
            end
        end
    end

    // Drain timer: loaded on the last accept, counts down through DRAIN.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_drain_cnt <= '0;
        end else if (w_accept && in_last) begin
            r_drain_cnt <= DW'(DP_LATENCY);
        end else if ((r_state == S_DRAIN) && (r_drain_cnt != '0)) begin
            r_drain_cnt <= r_drain_cnt - DW'(1);
        end
    end

    // Result capture once the pipeline has fully reflected the last point.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_out_area <= '0;
        end else if (w_drain_done) begin
            r_out_area <= dp_area;
        end
    end

endmodule

// File: tb/tb_day9_sequencer.sv
// Bench for day9_sequencer: two instances (default and 2-bit counter) share
// stimulus; each drives a behavioural area datapath with DP_LATENCY stages.
// Expected results are queued at job issue and checked by a monitor.
module tb_day9_sequencer;

    localparam int W  = 17;
    localparam int L  = 6;
    localparam int CW = 16;

    typedef struct {
        logic [2*W-1:0] area;
        int             cnt;
        int             cnt_sat;
    } exp_t;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_last = 1'b0;
    logic           out_ready = 1'b0;
    logic [W-1:0]   in_x = '0;
    logic [W-1:0]   in_y = '0;

    logic           in_ready  [2];
    logic           dp_reset  [2];
    logic           out_valid [2];
    logic           busy      [2];
    logic [W-1:0]   dp_x      [2];
    logic [W-1:0]   dp_y      [2];
    logic [2*W-1:0] dp_area   [2];
    logic [2*W-1:0] out_area  [2];
    logic [CW-1:0]  cnt_a;
    logic [1:0]     cnt_b;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   last_edge = 0;
    int   hold_left = 0;
    bit   rand_rdy = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    logic ov_prev = 1'b0;

    logic [W-1:0] jx [8];
    logic [W-1:0] jy [8];

    always #5 clock = ~clock;

    day9_sequencer #(.W(W), .DP_LATENCY(L), .CNT_W(CW)) u_dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready[0]),
        .in_x(in_x), .in_y(in_y), .in_last(in_last),
        .dp_reset(dp_reset[0]), .dp_x(dp_x[0]), .dp_y(dp_y[0]), .dp_area(dp_area[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready),
        .out_area(out_area[0]), .out_count(cnt_a), .busy(busy[0])
    );

    day9_sequencer #(.W(W), .DP_LATENCY(L), .CNT_W(2)) u_sat (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready[1]),
        .in_x(in_x), .in_y(in_y), .in_last(in_last),
        .dp_reset(dp_reset[1]), .dp_x(dp_x[1]), .dp_y(dp_y[1]), .dp_area(dp_area[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready),
        .out_area(out_area[1]), .out_count(cnt_b), .busy(busy[1])
    );

    function automatic logic [2*W-1:0] rect(input logic [W-1:0] x1, y1, x2, y2);
        longint dx, dy;
        dx = (x1 > x2) ? longint'(x1 - x2) : longint'(x2 - x1);
        dy = (y1 > y2) ? longint'(y1 - y2) : longint'(y2 - y1);
        return (2*W)'((dx + 1) * (dy + 1));
    endfunction

    // Reference: largest rectangle over every pair of the job's points.
    function automatic logic [2*W-1:0] ref_area(input int n);
        logic [2*W-1:0] best = '0;
        for (int i = 0; i < n; i++)
            for (int j = i; j < n; j++)
                if (rect(jx[i], jy[i], jx[j], jy[j]) > best) best = rect(jx[i], jy[i], jx[j], jy[j]);
        return best;
    endfunction

    // Behavioural datapath: incremental max over distinct points, delayed L cycles.
    logic [2*W-1:0] pipe    [2][L];
    logic [W-1:0]   sx      [2][16];
    logic [W-1:0]   sy      [2][16];
    int             ns      [2];
    logic [2*W-1:0] run_max [2];
    bit             fnd;

    initial begin
        for (int d = 0; d < 2; d++) begin
            ns[d] = 0;
            run_max[d] = '0;
            for (int i = 0; i < L; i++) pipe[d][i] = '0;
        end
    end

    assign dp_area[0] = pipe[0][L-1];
    assign dp_area[1] = pipe[1][L-1];

    always @(posedge clock) begin
        for (int d = 0; d < 2; d++) begin
            if (dp_reset[d]) begin
                ns[d] = 0;
                run_max[d] = '0;
                for (int i = 0; i < L; i++) pipe[d][i] <= '0;
            end else begin
                fnd = 0;
                for (int k = 0; k < ns[d]; k++)
                    if (sx[d][k] == dp_x[d] && sy[d][k] == dp_y[d]) fnd = 1;
                if (!fnd && ns[d] < 16) begin
                    if (run_max[d] == '0) run_max[d] = (2*W)'(1);
                    for (int k = 0; k < ns[d]; k++)
                        if (rect(sx[d][k], sy[d][k], dp_x[d], dp_y[d]) > run_max[d])
                            run_max[d] = rect(sx[d][k], sy[d][k], dp_x[d], dp_y[d]);
                    sx[d][ns[d]] = dp_x[d];
                    sy[d][ns[d]] = dp_y[d];
                    ns[d]++;
                end
                pipe[d][0] <= run_max[d];
                for (int i = 1; i < L; i++) pipe[d][i] <= pipe[d][i-1];
            end
        end
    end

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Edge counter and timestamp of the last accepted final beat.
    always @(posedge clock) begin
        cyc++;
        if (!reset && in_valid && in_ready[0] && in_last) last_edge = cyc;
    end

    // Result consumer: optional forced stall, otherwise always or randomly ready.
    always @(posedge clock) begin
        #2;
        if (out_valid[0] && hold_left > 0) begin
            out_ready = 1'b0;
            hold_left--;
        end else begin
            out_ready = rand_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    // Monitor: compares the presented result against the scoreboard head.
    always @(negedge clock) begin
        if (!reset && out_valid[0]) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result area=%0d count=%0d", out_area[0], cnt_a);
            end else begin
                mon_e = exp_q[0];
                if (!ov_prev) chk("result_latency", cyc - last_edge, L + 1);
                chk("out_area", out_area[0], mon_e.area);
                chk("out_count", cnt_a, mon_e.cnt);
                chk("in_ready_done", in_ready[0], 0);
                chk("busy_done", busy[0], 0);
                chk("sat_valid", out_valid[1], 1);
                chk("sat_area", out_area[1], mon_e.area);
                chk("sat_count", cnt_b, mon_e.cnt_sat);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
        ov_prev = out_valid[0] && !reset;
    end

    task automatic send_beat(input logic [W-1:0] x, input logic [W-1:0] y, input logic last);
        int t = 0;
        in_valid = 1'b1;
        in_x = x;
        in_y = y;
        in_last = last;
        forever begin
            @(negedge clock);
            if (in_ready[0]) break;
            t++;
            if (t > 200) begin
                chk("accept_timeout", 0, 1);
                break;
            end
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    // gap >= 0: fixed idle cycles before each beat; gap < 0: random 0..2.
    task automatic run_job(input int n, input int gap);
        exp_t e;
        int g;
        e.area = ref_area(n);
        e.cnt = n;
        e.cnt_sat = (n > 3) ? 3 : n;
        exp_q.push_back(e);
        for (int k = 0; k < n; k++) begin
            g = (gap >= 0) ? gap : int'($urandom_range(0, 2));
            repeat (g) begin
                @(posedge clock);
                #1;
            end
            send_beat(jx[k], jy[k], k == n - 1);
        end
        @(negedge clock);
        chk("busy_drain", busy[0], 1);
        @(posedge clock);
        #1;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (exp_q.size() != 0 && t < 400) begin
            @(posedge clock);
            t++;
        end
        if (exp_q.size() != 0) chk("result_timeout", exp_q.size(), 0);
        #1;
    endtask

    task automatic put(input int i, input int x, input int y);
        jx[i] = W'(x);
        jy[i] = W'(y);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_in_ready", in_ready[0], 1);
        chk("rst_dp_reset", dp_reset[0], 1);
        chk("rst_dp_x", dp_x[0], 0);
        chk("rst_dp_y", dp_y[0], 0);
        chk("rst_out_valid", out_valid[0], 0);
        chk("rst_out_area", out_area[0], 0);
        chk("rst_out_count", cnt_a, 0);
        chk("rst_busy", busy[0], 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        chk("arm_dp_reset", dp_reset[0], 1);
        @(posedge clock);
        #1;

        // Back-to-back two-point job.
        put(0, 1, 1); put(1, 4, 4);
        run_job(2, 0);
        wait_idle();

        // Single-point job straight from ARM to DRAIN.
        put(0, 5, 9);
        run_job(1, 0);
        wait_idle();

        // Same stream with idle gaps.
        put(0, 1, 1); put(1, 4, 4);
        run_job(2, 3);
        wait_idle();

        // Stalled result, then a job that would be wrong if not cleared.
        hold_left = 5;
        put(0, 10, 10); put(1, 20, 20);
        run_job(2, 0);
        wait_idle();
        put(0, 0, 0); put(1, 2, 3);
        run_job(2, 0);
        wait_idle();

        // Abort mid-FEED with reset; the aborted job produces nothing.
        send_beat(W'(10), W'(10), 1'b0);
        reset = 1'b1;
        @(negedge clock);
        chk("abort_dp_reset", dp_reset[0], 1);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        chk("abort_in_ready", in_ready[0], 1);
        chk("abort_count", cnt_a, 0);
        chk("abort_dp_x", dp_x[0], 0);
        chk("abort_out_valid", out_valid[0], 0);
        chk("abort_busy", busy[0], 0);
        @(posedge clock);
        #1;
        put(0, 1, 1); put(1, 4, 4);
        run_job(2, 0);
        wait_idle();

        // Five points: the 2-bit counter instance saturates at 3.
        put(0, 0, 0); put(1, 1, 2); put(2, 3, 1); put(3, 2, 2); put(4, 3, 3);
        run_job(5, 0);
        wait_idle();

        // Randomized jobs, random gaps and random result back-pressure.
        rand_rdy = 1;
        for (int j = 0; j < 15; j++) begin
            int n;
            n = int'($urandom_range(1, 6));
            for (int k = 0; k < n; k++) put(k, int'($urandom_range(0, 300)), int'($urandom_range(0, 300)));
            run_job(n, -1);
        end
        wait_idle();
        repeat (20) @(posedge clock);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/day9_sequencer.md
# day9_sequencer

Job sequencer for the day-9 rectangle-area datapath. It accepts a stream of tile coordinates over a valid/ready handshake and clears the datapath at the start of each job. It feeds the datapath one point per accepted beat, waits out the datapath pipeline after the last point, then captures the largest area and presents it on a valid/ready result port. It sits between the input parser/FIFO and the area datapath instance, which it drives directly.

## Interface

Parameters:
- W, 17: coordinate width. Must match the datapath.
- DP_LATENCY, 6: cycles from a new point appearing on dp_x/dp_y until dp_area reflects it. Equals 3 + multiplier latency (3).
- CNT_W, 16: width of the point counter.

Ports:
- clock, input, 1: clock.
- reset, input, 1: reset; synchronous, active-high.
- in_valid, input, 1: coordinate beat valid.
- in_ready, output, 1: sequencer accepts the beat.
- in_x, input, W: x coordinate.
- in_y, input, W: y coordinate.
- in_last, input, 1: marks the last point of the job.
- dp_reset, output, 1: synchronous reset to the datapath.
- dp_x, output, W: x coordinate to the datapath, registered.
- dp_y, output, W: y coordinate to the datapath, registered.
- dp_area, input, 2W: area from the datapath.
- out_valid, output, 1: result valid.
- out_ready, input, 1: result consumed.
- out_area, output, 2W: captured area, registered.
- out_count, output, CNT_W: points accepted in the job; saturating.
- busy, output, 1: high in FEED or DRAIN.

## Operation

- A beat is accepted when in_valid && in_ready.
- States and their outputs:
  - ARM: dp_reset=1, in_ready=1.
  - FEED: dp_reset=0, in_ready=1.
  - DRAIN: in_ready=0. Counts down.
  - DONE: in_ready=0, out_valid=1.
- dp_reset = reset | (state==ARM). The datapath is held cleared until the edge that accepts the first point, so stale coordinates never enter a new job.
- State transitions:
  - ARM, accept, !in_last -> FEED.
  - ARM, accept, in_last -> DRAIN. A single-point job is legal.
  - FEED, accept with in_last -> DRAIN. Otherwise stay in FEED.
  - DRAIN, drain_cnt==0 -> DONE. The same edge does out_area <= dp_area.
  - DONE, out_ready -> ARM.
- On every accept, dp_x/dp_y <= in_x/in_y.
- Outside accepts, dp_x/dp_y hold. The datapath treats a repeated point as a no-op, so input gaps do not change the result.
- Counters:
  - Accept in ARM: out_count <= 1.
  - Accept in FEED: out_count <= out_count+1, saturating at 2^CNT_W-1.
  - out_count holds through DRAIN and DONE.
- Drain counter:
  - drain_cnt <= DP_LATENCY on the accept carrying in_last.
  - Decrements each DRAIN cycle.
  - Width: clog2(DP_LATENCY+1).
- out_area and out_count are stable while out_valid=1 && !out_ready.

## Timing

- Reset values: state=ARM, in_ready=1, dp_reset=1, dp_x=0, dp_y=0, out_valid=0, out_area=0, out_count=0, busy=0, drain_cnt=0.
- Reset mid-job in any state:
  - Returns next cycle to ARM with the values above.
  - Any pending result is dropped.
  - The datapath is cleared in the same cycle.
- Last point accepted at edge E:
  - dp_x/dp_y carry it from E.
  - dp_area is valid after E+DP_LATENCY.
  - Capture happens at edge E+DP_LATENCY+1; out_valid rises after that edge.
  - With defaults, out_valid is observed 7 cycles after the last accept.
- Back-to-back points: one per cycle; no bubbles are required in FEED.
- Result handshake:
  - Completes on the edge with out_valid && out_ready.
  - The next job's first point can be accepted one cycle later, in ARM.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

## Test plan

- Points (1,1),(4,4) back-to-back, last on the second -> out_area=16, out_count=2. out_valid rises exactly DP_LATENCY+1 edges after the last accept.
- Single point (5,9) with in_last -> the DRAIN path is taken directly from ARM; out_area=1, out_count=1.
- Same stream as (1,1),(4,4) with 3 idle cycles between beats -> out_area=16, timing measured from the last accept.
- Job (10,10),(20,20) -> 121, with out_ready held low 5 cycles; out_valid and out_area stay stable and in_ready=0. Then job (0,0),(2,3) -> 12, proving the datapath was cleared between jobs.
- reset asserted mid-FEED after (10,10), then a new job (1,1),(4,4) -> no result for the aborted job; out_area=16, out_count=2.
- With CNT_W=2, a 5-point job -> out_count saturates at 3; the area is unaffected.
